// File: rtl/vit_trb_obuf.sv
// Viterbi traceback output stage: bit packer, saturating frame error count, show-ahead FIFO.
// Optional per-word error weight storage: define VIT_TRB_OBUF_WORD_ERR_EN.
module vit_trb_obuf #(
    parameter int pCODE_GEN_NUM = 2,
    parameter int pTAG_W        = 4,
    parameter int pERR_CNT_W    = 16,
    parameter int pDAT_W        = 8,
    parameter int pFIFO_DEPTH_W = 4
) (
    input  logic                                       iclk,
    input  logic                                       ireset,
    input  logic                                       iclkena,
    input  logic                                       isop,
    input  logic                                       ival,
    input  logic                                       ieop,
    input  logic [pTAG_W-1:0]                          itag,
    input  logic                                       idat,
    input  logic [pCODE_GEN_NUM-1:0]                   ibiterr,
    output logic                                       ordy,
    input  logic                                       ireq,
    output logic                                       oval,
    output logic                                       osop,
    output logic                                       oeop,
    output logic [pTAG_W-1:0]                          otag,
    output logic [pDAT_W-1:0]                          odat,
    output logic [$clog2(pDAT_W)-1:0]                  onum_m1,
    output logic [pERR_CNT_W-1:0]                      oerrcnt,
    output logic                                       oerr_sat,
    output logic [$clog2(pDAT_W*pCODE_GEN_NUM+1)-1:0]  owerrcnt,
    output logic                                       ooverflow
);

    localparam int NUM_W  = $clog2(pDAT_W);
    localparam int WGT_W  = $clog2(pCODE_GEN_NUM + 1);
    localparam int DEPTH  = 1 << pFIFO_DEPTH_W;
    localparam int BASE_W = 3 + pTAG_W + NUM_W + pDAT_W + pERR_CNT_W;
`ifdef VIT_TRB_OBUF_WORD_ERR_EN
    localparam int WE_W   = $clog2(pDAT_W*pCODE_GEN_NUM+1);
    localparam int EW     = BASE_W + WE_W;
`else
    localparam int EW     = BASE_W;
`endif
    localparam logic [pERR_CNT_W-1:0] ERR_MAX = '1;

    // packer / frame state
    logic                    r_act;
    logic                    r_first;
    logic [pTAG_W-1:0]       r_tag;
    logic [NUM_W-1:0]        r_idx;
    logic [pDAT_W-1:0]       r_sh;
    logic [pERR_CNT_W-1:0]   r_ecnt;
    logic                    r_esat;
    logic                    r_pv;
    logic [EW-1:0]           r_pw;

    // fifo state
    logic [EW-1:0]              r_mem [DEPTH];
    logic [pFIFO_DEPTH_W-1:0]   r_wp;
    logic [pFIFO_DEPTH_W-1:0]   r_rp;
    logic [pFIFO_DEPTH_W:0]     r_used;
    logic [EW-1:0]              r_head;
    logic                       r_oval;
    logic                       r_ovf;
    logic                       r_rdy;

    logic                    w_acc;
    logic                    w_start;
    logic                    w_take;
    logic                    w_done;
    logic                    w_sop;
    logic [pTAG_W-1:0]       w_tag;
    logic [NUM_W-1:0]        w_idx;
    logic [pDAT_W-1:0]       w_sh;
    logic [WGT_W-1:0]        w_wgt;
    logic [pERR_CNT_W-1:0]   w_ebase;
    logic [pERR_CNT_W:0]     w_esum;
    logic [pERR_CNT_W-1:0]   w_ecnt;
    logic                    w_esat;
    logic [EW-1:0]           w_entry;
    logic                    w_pop;
    logic                    w_xfer;
    logic                    w_full;
    logic                    w_wr;
    logic                    w_drop;
    logic [pFIFO_DEPTH_W:0]  w_used_nxt;

    assign w_acc   = iclkena & ival;
    assign w_start = w_acc & isop;
    assign w_take  = w_acc & (isop | r_act);
    assign w_idx   = w_start ? '0 : r_idx;
    assign w_sop   = w_start | r_first;
    assign w_tag   = w_start ? itag : r_tag;
    assign w_done  = w_take & (ieop | (w_idx == NUM_W'(pDAT_W-1)));
    assign w_sh    = (w_start ? '0 : r_sh) | (pDAT_W'(idat) << w_idx);
    assign w_ebase = w_start ? '0 : r_ecnt;

    always_comb begin
        w_wgt = '0;
        for (int i = 0; i < pCODE_GEN_NUM; i++)
            w_wgt = w_wgt + WGT_W'(ibiterr[i]);
    end

    assign w_esum = {1'b0, w_ebase} + (pERR_CNT_W+1)'(w_wgt);
    assign w_ecnt = (w_esum > {1'b0, ERR_MAX}) ? ERR_MAX : w_esum[pERR_CNT_W-1:0];
    assign w_esat = (~w_start & r_esat) | (w_esum >= {1'b0, ERR_MAX});

`ifdef VIT_TRB_OBUF_WORD_ERR_EN
    logic [WE_W-1:0] r_werr;
    logic [WE_W-1:0] w_werr;
    assign w_werr  = (w_start ? '0 : r_werr) + WE_W'(w_wgt);
    assign w_entry = {w_werr, w_sop, ieop, w_esat, w_tag, w_idx, w_ecnt, w_sh};
    assign owerrcnt = r_head[BASE_W +: WE_W];

    always_ff @(posedge iclk) begin
        if (ireset)
            r_werr <= '0;
        else if (w_take)
            r_werr <= w_done ? '0 : w_werr;
    end
`else
    assign w_entry  = {w_sop, ieop, w_esat, w_tag, w_idx, w_ecnt, w_sh};
    assign owerrcnt = '0;
`endif

    // a full FIFO still accepts the write when the head pops the same cycle
    assign w_xfer     = iclkena & r_oval & ireq;
    assign w_pop      = iclkena & (r_used != '0) & (~r_oval | ireq);
    assign w_full     = (r_used == (pFIFO_DEPTH_W+1)'(DEPTH));
    assign w_wr       = iclkena & r_pv & (~w_full | w_pop);
    assign w_drop     = iclkena & r_pv & w_full & ~w_pop;
    assign w_used_nxt = r_used + (pFIFO_DEPTH_W+1)'(w_wr) - (pFIFO_DEPTH_W+1)'(w_pop);

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_act   <= 1'b0;
            r_first <= 1'b0;
            r_tag   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_ecnt  <= '0;
            r_esat  <= 1'b0;
            r_pv    <= 1'b0;
            r_pw    <= '0;
        end else if (iclkena) begin
            r_pv <= w_done;
            if (w_done)
                r_pw <= w_entry;
            if (w_take) begin
                r_tag  <= w_tag;
                r_ecnt <= w_ecnt;
                r_esat <= w_esat;
                if (w_done) begin
                    r_idx   <= '0;
                    r_sh    <= '0;
                    r_first <= 1'b0;
                    r_act   <= ~ieop;
                end else begin
                    r_idx   <= w_idx + 1'b1;
                    r_sh    <= w_sh;
                    r_first <= w_sop;
                    r_act   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (w_wr)
            r_mem[r_wp] <= r_pw;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_used <= '0;
            r_head <= '0;
            r_oval <= 1'b0;
            r_ovf  <= 1'b0;
            r_rdy  <= 1'b0;
        end else if (iclkena) begin
            if (w_pop) begin
                r_head <= r_mem[r_rp];
                r_rp   <= r_rp + 1'b1;
                r_oval <= 1'b1;
            end else if (w_xfer) begin
                r_oval <= 1'b0;
            end
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_drop)
                r_ovf <= 1'b1;
            r_used <= w_used_nxt;
            r_rdy  <= w_used_nxt < (pFIFO_DEPTH_W+1)'(DEPTH-2);
        end
    end

    assign ordy      = r_rdy;
    assign oval      = r_oval;
    assign ooverflow = r_ovf;
    assign odat      = r_head[0 +: pDAT_W];
    assign oerrcnt   = r_head[pDAT_W +: pERR_CNT_W];
    assign onum_m1   = r_head[pDAT_W+pERR_CNT_W +: NUM_W];
    assign otag      = r_head[pDAT_W+pERR_CNT_W+NUM_W +: pTAG_W];
    assign oerr_sat  = r_head[BASE_W-3];
    assign oeop      = r_head[BASE_W-2];
    assign osop      = r_head[BASE_W-1];

endmodule
